// File: rtl/sram_req_bridge.sv
// sram_req_bridge: initiator side of an sram_if port.
// Turns a valid/ready request stream into single-cycle SRAM accesses and
// returns read data, in issue order, through a small credit-managed FIFO.
module sram_req_bridge #(
  parameter int unsigned BIT_WIDTH  = 64,
  parameter int unsigned WORD_DEPTH = 512,
  parameter int unsigned RSP_DEPTH  = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  // request stream
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_we_i,
  input  logic [BIT_WIDTH/8-1:0]        req_bm_i,
  input  logic [$clog2(WORD_DEPTH)-1:0] req_addr_i,
  input  logic [BIT_WIDTH-1:0]          req_wdata_i,
  // response stream
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [BIT_WIDTH-1:0]          rsp_rdata_o,
  // SRAM side
  output logic                          sram_en_o,
  output logic                          sram_wen_o,
  output logic [BIT_WIDTH/8-1:0]        sram_bm_o,
  output logic [$clog2(WORD_DEPTH)-1:0] sram_addr_o,
  output logic [BIT_WIDTH-1:0]          sram_dat_o,
  input  logic [BIT_WIDTH-1:0]          sram_dat_i
);

  // Pointer, count and occupancy widths; RSP_DEPTH need not be a power of two.
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic                 alive_q,       alive_d;
  logic                 rd_inflight_q, rd_inflight_d;
  logic [CW-1:0]        count_q,       count_d;
  logic [PW-1:0]        wr_ptr_q,      wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q,      rd_ptr_d;
  logic [BIT_WIDTH-1:0] mem_q [RSP_DEPTH];

  logic          fire;
  logic          push;
  logic          pop;
  logic          rd_credit;
  logic [OW-1:0] occupancy;

  // Pointer increment with wrap at RSP_DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RSP_DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Handshake, credit and SRAM command path.
  always_comb begin
    occupancy   = OW'(count_q) + OW'(rd_inflight_q);
    rd_credit   = (occupancy < OW'(RSP_DEPTH));
    // Read credit uses only registered state, so rsp_ready_i never reaches req_ready_o.
    req_ready_o = alive_q & (req_we_i | rd_credit);
    fire        = req_valid_i & req_ready_o;
    sram_en_o   = fire;
    sram_wen_o  = req_we_i;
    sram_bm_o   = req_bm_i;
    sram_addr_o = req_addr_i;
    sram_dat_o  = req_wdata_i;
  end

  // Response FIFO status and head data.
  always_comb begin
    rsp_valid_o = (count_q != '0);
    rsp_rdata_o = mem_q[rd_ptr_q];
    push        = rd_inflight_q;
    pop         = rsp_valid_o & rsp_ready_i;
  end

  // Next-state for in-flight flag, FIFO count and pointers.
  always_comb begin
    alive_d       = 1'b1;
    rd_inflight_d = fire & ~req_we_i;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers; reset drops any in-flight read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      alive_q       <= 1'b0;
      rd_inflight_q <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      alive_q       <= alive_d;
      rd_inflight_q <= rd_inflight_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage captures SRAM read data the cycle after a read fire.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sram_dat_i;
    end
  end

  // Credit accounting must make overflow impossible.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    push |-> ((count_q != CW'(RSP_DEPTH)) || pop));

endmodule
